// File: rtl/aidc_lite_buffer_drain_if.sv
// Buffer read port plus the registered valid/ready output stream of the
// AIDC-Lite buffer drain; master is the drain, slave is buffer + downstream.
interface aidc_lite_buffer_drain_if #(
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] raddr;
  logic [63:0]           rdata;
  logic                  valid;
  logic [63:0]           data;
  logic                  last;
  logic                  ready;

  modport master (
    output raddr,
    input  rdata,
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  raddr,
    output rdata,
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/aidc_lite_buffer_drain.sv
// Read-side sequencer for the AIDC-Lite 64-bit word buffer: walks a wrapping
// address range and streams each word out with last/done signalling.
module aidc_lite_buffer_drain #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   cnt_i,
  output logic                  busy_o,
  output logic                  done_o,
  aidc_lite_buffer_drain_if.master bus
);

  localparam int                DEPTH_INT = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH   = DEPTH_INT[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   rd_left_q, rd_left_d;
  logic [ADDR_WIDTH:0]   out_left_q, out_left_d;
  logic                  valid_q, valid_d;
  logic [63:0]           data_q, data_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  hs;
  logic                  load;
  logic [ADDR_WIDTH:0]   cnt_clamped;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rd_left_d   = rd_left_q;
    out_left_d  = out_left_q;
    valid_d     = valid_q;
    data_d      = data_q;
    last_d      = last_q;

    hs          = valid_q && bus.ready;
    load        = (state_q == RUN) && (rd_left_q != '0) && (!valid_q || bus.ready);
    cnt_clamped = (cnt_i > DEPTH) ? DEPTH : cnt_i;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cnt_clamped == '0) begin
            state_d = DONE;
          end else begin
            state_d    = RUN;
            rd_ptr_d   = base_i;
            rd_left_d  = cnt_clamped;
            out_left_d = cnt_clamped;
          end
        end
      end
      RUN: begin
        // A new word may replace the current one in the same cycle it is taken
        if (load) begin
          data_d    = bus.rdata;
          valid_d   = 1'b1;
          last_d    = (rd_left_q == ONE);
          rd_ptr_d  = rd_ptr_q + 1'b1;
          rd_left_d = rd_left_q - 1'b1;
        end else if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
        if (hs) begin
          out_left_d = out_left_q - 1'b1;
          if (out_left_q == ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign bus.raddr = rd_ptr_q;
  assign bus.valid = valid_q;
  assign bus.data  = data_q;
  assign bus.last  = last_q;

endmodule
